// File: rtl/load_reader.sv
// Single-outstanding data-memory load unit: issues one word read, extracts and extends the addressed lane.
// Optional macro LOAD_TIMEOUT_EN aborts a WAIT that exceeds TIMEOUT_CYCLES cycles without mem_ack.
module load_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned LW_ALIGN_CHK   = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [2:0]  ltype,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] Loaddata,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // Memory handshake: mem_req is a one-cycle pulse; the single read it opens is closed by
  // the first mem_ack seen in REQ or WAIT. Acks in any other state belong to no transaction.
  logic [2:0]  state_q, state_d;
  logic [2:0]  ltype_q;
  logic [1:0]  off_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] ld_q;

  logic        illegal;
  logic        ack_take;
  logic        timeout_hit;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] result;

  always_comb begin
    illegal = 1'b0;
    case (ltype)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = (LW_ALIGN_CHK != 0) && addr[0];
      3'b010:         illegal = (LW_ALIGN_CHK != 0) && (addr[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
  end

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (off_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    result = mem_rdata;
    case (ltype_q)
      3'b000:  result = {{24{lane_b[7]}}, lane_b};
      3'b001:  result = {{16{lane_h[15]}}, lane_h};
      3'b100:  result = {24'h0, lane_b};
      3'b101:  result = {16'h0, lane_h};
      default: result = mem_rdata;
    endcase
  end

  assign ack_take = mem_ack && ((state_q == S_REQ) || (state_q == S_WAIT));

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside WAIT so every WAIT entry starts a fresh count.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT && !mem_ack) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = illegal ? S_ERR : S_REQ;
      S_REQ:  state_d = mem_ack ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (mem_ack)          state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // err is raised on the cycle leaving ERR, so an aborted request reports two cycles after start.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ltype_q    <= 3'b000;
      off_q      <= 2'b00;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ld_q       <= 32'h0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == S_REQ);
      done_q    <= (state_d == S_DONE);
      err_q     <= (state_q == S_ERR);
      if (state_q == S_IDLE && start) begin
        ltype_q <= ltype;
        off_q   <= addr[1:0];
        if (!illegal) mem_addr_q <= {addr[31:2], 2'b00};
      end
      if (ack_take) ld_q <= result;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign Loaddata  = ld_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_reader.sv
// Randomized bench for load_reader: a transaction-level model sets per-cycle expectation windows,
// one negedge process compares every output against them.
module tb_load_reader;

  localparam int TO = 16;
  localparam int ALIGN = 1;

  logic        CLK, reset, start, mem_ack;
  logic [31:0] addr, mem_rdata;
  logic [2:0]  ltype;
  logic        mem_req, busy, done, err;
  logic [31:0] mem_addr, Loaddata;
  logic [2:0]  dbg_state;

  load_reader #(.TIMEOUT_CYCLES(TO), .LW_ALIGN_CHK(ALIGN)) dut (
    .CLK(CLK), .reset(reset), .start(start), .addr(addr), .ltype(ltype),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err), .Loaddata(Loaddata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // expectation windows, written only by the driver
  int w_lo = -1, w_hi = -1, req_c = -1, done_c = -1, err_c = -1;
  logic [31:0] exp_maddr = 32'h0;
  logic [31:0] ld_pend = 32'h0;
  logic [31:0] ld_model = 32'h0;
  logic [31:0] exp_q[$];

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", n, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", n, cyc, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [2:0] t);
    if (!(t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5)) return 1'b0;
    if (ALIGN != 0 && (t == 3'd1 || t == 3'd5) && (a % 2 != 0)) return 1'b0;
    if (ALIGN != 0 && t == 3'd2 && (a % 4 != 0)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] d, input logic [31:0] a, input logic [2:0] t);
    int unsigned b, h;
    b = (d >> (8 * (a % 4))) & 32'hFF;
    h = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (t)
      3'd0: return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
      3'd1: return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return d;
    endcase
  endfunction

  // scoreboard / compare process
  always @(negedge CLK) begin
    if (!reset) begin
      ld_model = 32'h0;
      exp_q.delete();
    end else if (cyc == done_c) begin
      ld_model = ld_pend;
    end
    chk1("busy", busy, (cyc >= w_lo && cyc <= w_hi));
    chk1("mem_req", mem_req, (cyc == req_c));
    if (cyc == req_c) chk32("mem_addr", mem_addr, exp_maddr);
    chk1("done", done, (cyc == done_c));
    chk1("err", err, (cyc == err_c));
    chk32("Loaddata", Loaddata, ld_model);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected cyc=%0d actual=done expected=none", cyc);
      end else begin
        chk32("done_data", Loaddata, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic do_load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d,
                         input int dly, input bit poke);
    int c0, ack_c;
    bit ok, timed;
    @(posedge CLK); #1;
    c0 = cyc; start = 1'b1; addr = a; ltype = t;
    ok = legal(a, t);
    timed = 1'b0;
    ack_c = -1;
    w_lo = c0 + 1;
    if (!ok) begin
      w_hi = c0 + 1; err_c = c0 + 2; req_c = -1; done_c = -1;
    end else begin
      req_c = c0 + 1; exp_maddr = {a[31:2], 2'b00}; err_c = -1;
      ack_c = c0 + 1 + dly; done_c = ack_c + 1; w_hi = done_c;
`ifdef LOAD_TIMEOUT_EN
      if (dly > TO) begin
        timed = 1'b1; w_hi = c0 + 2 + TO; err_c = c0 + 3 + TO; done_c = -1;
      end
`endif
      if (!timed) begin
        ld_pend = ext(d, a, t);
        exp_q.push_back(ld_pend);
      end
    end
    @(posedge CLK); #1;
    start = 1'b0;
    while (cyc <= w_hi) begin
      mem_ack = (ok && !timed && cyc == ack_c);
      mem_rdata = mem_ack ? d : $urandom;
      start = (poke && cyc == c0 + 2);
      addr = $urandom; ltype = 3'($urandom_range(0, 7));
      @(posedge CLK); #1;
    end
    mem_ack = 1'b0; start = 1'b0;
  endtask

  task automatic idle_ack();
    @(posedge CLK); #1;
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
  endtask

  task automatic reset_mid_wait();
    int c0;
    @(posedge CLK); #1;
    c0 = cyc; start = 1'b1; addr = 32'h80; ltype = 3'd2;
    w_lo = c0 + 1; w_hi = c0 + 1000; req_c = c0 + 1; exp_maddr = 32'h80; done_c = -1; err_c = -1;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    reset = 1'b0;
    w_lo = -1; w_hi = -1; req_c = -1;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_Loaddata", Loaddata, 32'h0);
    chk32("rst_state", {29'h0, dbg_state}, 32'h0);
    @(negedge CLK); #2;
    reset = 1'b1;
    @(posedge CLK); #1;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk32("post_rst_state", {29'h0, dbg_state}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] tt[8];
    tt = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    reset = 1'b0; start = 1'b0; addr = 32'h0; ltype = 3'd0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // model pins
    chk32("model_lb", ext(32'h80112233, 32'h103, 3'd0), 32'hFFFFFF80);
    chk32("model_lhu", ext(32'hBEEF1234, 32'h22, 3'd5), 32'h0000BEEF);
    chk32("model_lh", ext(32'hBEEF1234, 32'h22, 3'd1), 32'hFFFFBEEF);
    chk32("model_lbu", ext(32'h80112233, 32'h101, 3'd4), 32'h00000022);

    repeat (3) @(posedge CLK);
    #1;
    chk32("reset_Loaddata", Loaddata, 32'h0);
    chk1("reset_busy", busy, 1'b0);
    @(negedge CLK); #2;
    reset = 1'b1;

    do_load(32'h103, 3'd0, 32'h80112233, 1, 1'b0);
    chk32("lb_literal", Loaddata, 32'hFFFFFF80);
    do_load(32'h22, 3'd5, 32'hBEEF1234, 1, 1'b0);
    chk32("lhu_literal", Loaddata, 32'h0000BEEF);
    do_load(32'h22, 3'd1, 32'hBEEF1234, 1, 1'b0);
    chk32("lh_literal", Loaddata, 32'hFFFFBEEF);
    do_load(32'h41, 3'd2, 32'h0, 1, 1'b0);
    chk32("lw_misalign_hold", Loaddata, 32'hFFFFBEEF);
    do_load(32'h40, 3'd3, 32'h0, 1, 1'b0);
    chk32("ltype011_hold", Loaddata, 32'hFFFFBEEF);
    do_load(32'h40, 3'd2, 32'hCAFEF00D, 5, 1'b1);
    chk32("lw_delay_literal", Loaddata, 32'hCAFEF00D);
    do_load(32'h7, 3'd4, 32'hA5B6C7D8, 0, 1'b1);
    chk32("ack_in_req", Loaddata, 32'h000000A5);
    idle_ack();
    reset_mid_wait();

    for (int i = 0; i < 60; i++) begin
      do_load($urandom, tt[$urandom_range(0, 7)], $urandom, $urandom_range(0, 6),
              1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle_ack();
    end

`ifdef LOAD_TIMEOUT_EN
    do_load(32'h200, 3'd2, 32'h11223344, TO, 1'b0);
    chk32("ack_at_limit", Loaddata, 32'h11223344);
    do_load(32'h204, 3'd2, 32'h55667788, TO + 1, 1'b0);
    chk32("timeout_hold", Loaddata, 32'h11223344);
`endif

    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_results actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
